// File: rtl/encdec_pkg.sv
// Shared types and helpers for the 8-line encoder/decoder pair.
// The lowest-set-bit search is reused by the decoder-side benches.
package encdec_pkg;

    localparam int N     = 8;
    localparam int IDX_W = 3;

    typedef logic [IDX_W-1:0] idx_t;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } stage_t;

    // Scanning from the top down leaves the lowest set bit as the final winner.
    function automatic idx_t lsb_index(input logic [N-1:0] vec);
        idx_t idx;
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = idx_t'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/prio_enc8x3.sv
// Combinational 8-to-3 priority encoder: bit 0 has the highest priority.
// Reports index 0 when no input is set; 'any' tells that case apart.
module prio_enc8x3
    import encdec_pkg::*;
(
    input  logic [N-1:0] req,
    output idx_t         idx,
    output logic         any
);

    assign idx = lsb_index(req);
    assign any = |req;

endmodule

// File: rtl/prio_encoder8x3_hs.sv
// Latching 8-to-3 priority encoder with a one-entry valid/ready output stage.
// Requests collect in a pending register and are handed out lowest index first.
module prio_encoder8x3_hs
    import encdec_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req_in,
    input  logic         clear_in,
    output idx_t         code_out,
    output logic         code_valid,
    input  logic         code_ready,
    output logic [N-1:0] pending_out,
    output logic         drop_pulse
);

    logic [N-1:0] pending;
    logic [N-1:0] pending_next;
    logic [N-1:0] load_mask;
    idx_t         enc_idx;
    logic         enc_any;
    logic         load;
    logic         drop_next;
    stage_t       state;
    stage_t       state_next;

    prio_enc8x3 u_enc (
        .req (pending),
        .idx (enc_idx),
        .any (enc_any)
    );

    assign code_valid  = (state == ST_FULL);
    assign pending_out = pending;

    // A fresh request on the bit being loaded re-pends it rather than counting as a drop.
    always_comb begin
        load         = (!code_valid || code_ready) && enc_any;
        load_mask    = load ? ({{(N-1){1'b0}}, 1'b1} << enc_idx) : '0;
        pending_next = (pending & ~load_mask) | req_in;
        drop_next    = |(req_in & pending & ~load_mask);
    end

    always_comb begin
        state_next = state;
        if (clear_in) begin
            state_next = ST_EMPTY;
        end else if (load) begin
            state_next = ST_FULL;
        end else if (code_valid && code_ready) begin
            state_next = ST_EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // clear_in flushes the queue but leaves code_out at its last value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending    <= '0;
            code_out   <= '0;
            drop_pulse <= 1'b0;
        end else if (clear_in) begin
            pending    <= '0;
            drop_pulse <= 1'b0;
        end else begin
            pending    <= pending_next;
            drop_pulse <= drop_next;
            if (load) begin
                code_out <= enc_idx;
            end
        end
    end

endmodule

// File: tb/tb_prio_encoder8x3_hs.sv
// Directed bench for prio_encoder8x3_hs: each scenario task steps a table of
// inputs and compares {valid, code, pending, drop} one cycle later.
module tb_prio_encoder8x3_hs;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] req_in;
    logic       clear_in;
    logic [2:0] code_out;
    logic       code_valid;
    logic       code_ready;
    logic [7:0] pending_out;
    logic       drop_pulse;

    int n_checks = 0;
    int n_fail   = 0;

    prio_encoder8x3_hs dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_in      (req_in),
        .clear_in    (clear_in),
        .code_out    (code_out),
        .code_valid  (code_valid),
        .code_ready  (code_ready),
        .pending_out (pending_out),
        .drop_pulse  (drop_pulse)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        logic [7:0]  rq [0:1] = '{8'h0B, 8'h00};
        logic [12:0] ex [0:1] = '{{1'b0, 3'd0, 8'h0B, 1'b0}, {1'b1, 3'd0, 8'h0A, 1'b0}};
        logic [12:0] got;
        rst_n = 1'b0; req_in = 8'h00; clear_in = 1'b0; code_ready = 1'b0;
        #3;
        got = {code_valid, code_out, pending_out, drop_pulse};
        n_checks++;
        if (got !== 13'd0) begin
            n_fail++;
            $display("FAIL reset_init: got %b required all zero", got);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            req_in = rq[i];
            @(posedge clk); #1;
            got = {code_valid, code_out, pending_out, drop_pulse};
            n_checks++;
            if (got !== ex[i]) begin
                n_fail++;
                $display("FAIL reset_setup[%0d]: got v/code/pend/drop=%b/%0d/%h/%b required %b/%0d/%h/%b",
                         i, got[12], got[11:9], got[8:1], got[0], ex[i][12], ex[i][11:9], ex[i][8:1], ex[i][0]);
            end
        end
        #2 rst_n = 1'b0;
        #1;
        got = {code_valid, code_out, pending_out, drop_pulse};
        n_checks++;
        if (got !== 13'd0) begin
            n_fail++;
            $display("FAIL reset_async: got v/code/pend/drop=%b/%0d/%h/%b required all zero",
                     got[12], got[11:9], got[8:1], got[0]);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            got = {code_valid, code_out, pending_out, drop_pulse};
            n_checks++;
            if (got !== 13'd0) begin
                n_fail++;
                $display("FAIL reset_idle[%0d]: got v/code/pend/drop=%b/%0d/%h/%b required all zero",
                         i, got[12], got[11:9], got[8:1], got[0]);
            end
        end
    endtask

    task automatic test_burst_drain();
        logic [12:0] got, ex;
        logic [7:0]  ones;
        ones = 8'hFF;
        code_ready = 1'b1; clear_in = 1'b0;
        for (int i = 0; i < 10; i++) begin
            req_in = (i == 0) ? 8'hFF : 8'h00;
            @(posedge clk); #1;
            if (i == 0)      ex = {1'b0, 3'd0, 8'hFF, 1'b0};
            else if (i < 9)  ex = {1'b1, 3'(i - 1), ones << i, 1'b0};
            else             ex = {1'b0, 3'd7, 8'h00, 1'b0};
            got = {code_valid, code_out, pending_out, drop_pulse};
            n_checks++;
            if (got !== ex) begin
                n_fail++;
                $display("FAIL burst[%0d]: got v/code/pend/drop=%b/%0d/%h/%b required %b/%0d/%h/%b",
                         i, got[12], got[11:9], got[8:1], got[0], ex[12], ex[11:9], ex[8:1], ex[0]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [7:0]  rq [0:7] = '{8'h24, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        logic        rd [0:7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [12:0] ex [0:7] = '{{1'b0, 3'd7, 8'h24, 1'b0}, {1'b1, 3'd2, 8'h20, 1'b0},
                                  {1'b1, 3'd2, 8'h20, 1'b0}, {1'b1, 3'd2, 8'h20, 1'b0},
                                  {1'b1, 3'd2, 8'h20, 1'b0}, {1'b1, 3'd2, 8'h20, 1'b0},
                                  {1'b1, 3'd5, 8'h00, 1'b0}, {1'b0, 3'd5, 8'h00, 1'b0}};
        logic [12:0] got;
        clear_in = 1'b0;
        for (int i = 0; i < 8; i++) begin
            req_in = rq[i]; code_ready = rd[i];
            @(posedge clk); #1;
            got = {code_valid, code_out, pending_out, drop_pulse};
            n_checks++;
            if (got !== ex[i]) begin
                n_fail++;
                $display("FAIL backpressure[%0d]: got v/code/pend/drop=%b/%0d/%h/%b required %b/%0d/%h/%b",
                         i, got[12], got[11:9], got[8:1], got[0], ex[i][12], ex[i][11:9], ex[i][8:1], ex[i][0]);
            end
        end
    endtask

    task automatic test_priority_preempt();
        logic [7:0]  rq [0:6] = '{8'h20, 8'h00, 8'h80, 8'h01, 8'h00, 8'h00, 8'h00};
        logic        rd [0:6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [12:0] ex [0:6] = '{{1'b0, 3'd5, 8'h20, 1'b0}, {1'b1, 3'd5, 8'h00, 1'b0},
                                  {1'b1, 3'd5, 8'h80, 1'b0}, {1'b1, 3'd5, 8'h81, 1'b0},
                                  {1'b1, 3'd0, 8'h80, 1'b0}, {1'b1, 3'd7, 8'h00, 1'b0},
                                  {1'b0, 3'd7, 8'h00, 1'b0}};
        logic [12:0] got;
        clear_in = 1'b0;
        for (int i = 0; i < 7; i++) begin
            req_in = rq[i]; code_ready = rd[i];
            @(posedge clk); #1;
            got = {code_valid, code_out, pending_out, drop_pulse};
            n_checks++;
            if (got !== ex[i]) begin
                n_fail++;
                $display("FAIL preempt[%0d]: got v/code/pend/drop=%b/%0d/%h/%b required %b/%0d/%h/%b",
                         i, got[12], got[11:9], got[8:1], got[0], ex[i][12], ex[i][11:9], ex[i][8:1], ex[i][0]);
            end
        end
    endtask

    task automatic test_drop_repend();
        logic [7:0]  rq [0:7] = '{8'h01, 8'h00, 8'h08, 8'h08, 8'h00, 8'h08, 8'h00, 8'h00};
        logic        rd [0:7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [12:0] ex [0:7] = '{{1'b0, 3'd7, 8'h01, 1'b0}, {1'b1, 3'd0, 8'h00, 1'b0},
                                  {1'b1, 3'd0, 8'h08, 1'b0}, {1'b1, 3'd0, 8'h08, 1'b1},
                                  {1'b1, 3'd0, 8'h08, 1'b0}, {1'b1, 3'd3, 8'h08, 1'b0},
                                  {1'b1, 3'd3, 8'h00, 1'b0}, {1'b0, 3'd3, 8'h00, 1'b0}};
        logic [12:0] got;
        clear_in = 1'b0;
        for (int i = 0; i < 8; i++) begin
            req_in = rq[i]; code_ready = rd[i];
            @(posedge clk); #1;
            got = {code_valid, code_out, pending_out, drop_pulse};
            n_checks++;
            if (got !== ex[i]) begin
                n_fail++;
                $display("FAIL drop_repend[%0d]: got v/code/pend/drop=%b/%0d/%h/%b required %b/%0d/%h/%b",
                         i, got[12], got[11:9], got[8:1], got[0], ex[i][12], ex[i][11:9], ex[i][8:1], ex[i][0]);
            end
        end
    endtask

    task automatic test_clear();
        logic [7:0]  rq [0:5] = '{8'hF0, 8'h00, 8'h10, 8'h01, 8'h00, 8'h00};
        logic        rd [0:5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic        cl [0:5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [12:0] ex [0:5] = '{{1'b0, 3'd3, 8'hF0, 1'b0}, {1'b1, 3'd4, 8'hE0, 1'b0},
                                  {1'b1, 3'd4, 8'hF0, 1'b0}, {1'b0, 3'd4, 8'h00, 1'b0},
                                  {1'b0, 3'd4, 8'h00, 1'b0}, {1'b0, 3'd4, 8'h00, 1'b0}};
        logic [12:0] got;
        for (int i = 0; i < 6; i++) begin
            req_in = rq[i]; code_ready = rd[i]; clear_in = cl[i];
            @(posedge clk); #1;
            got = {code_valid, code_out, pending_out, drop_pulse};
            n_checks++;
            if (got !== ex[i]) begin
                n_fail++;
                $display("FAIL clear[%0d]: got v/code/pend/drop=%b/%0d/%h/%b required %b/%0d/%h/%b",
                         i, got[12], got[11:9], got[8:1], got[0], ex[i][12], ex[i][11:9], ex[i][8:1], ex[i][0]);
            end
        end
        clear_in = 1'b0;
    endtask

    initial begin
        test_reset();
        test_burst_drain();
        test_backpressure();
        test_priority_preempt();
        test_drop_repend();
        test_clear();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
